sized_dp_ram: RTL and testbench
===============================

SIZED_DP_RAM -- requirements
Module: sized_dp_ram

Interface
REQ-001 Parameter DATAWIDTH, default 32, word width in bits; legal values 32 and 64.
REQ-002 Parameter MEMDEPTH, default 1024, number of words; power of two.
REQ-003 Parameter ADDRWIDTH, default 12, byte address width; SHALL equal log2(MEMDEPTH*DATAWIDTH/8).
REQ-004 HCLK  input  1  single clock for both ports.
REQ-005 HRESETn  input  1  reset, asynchronous, active-low.
REQ-006 ready  output  1  high once memory initialisation is complete.
REQ-007 en_a / en_b  input  1  access request, port A / port B.
REQ-008 we_a / we_b  input  1  1 = write, 0 = read; sampled only when en is high.
REQ-009 addr_a / addr_b  input  ADDRWIDTH  byte address.
REQ-010 size_a / size_b  input  hsize_t  access size (BYTE, HALFWORD, WORD, DWORD).
REQ-011 wdata_a / wdata_b  input  DATAWIDTH  write data, lane-aligned to address.
REQ-012 rdata_a / rdata_b  output  DATAWIDTH  read data, lane-aligned, unselected lanes zero.
REQ-013 rvalid_a / rvalid_b  output  1  one-cycle pulse marking valid rdata.
REQ-014 err_a / err_b  output  1  one-cycle pulse marking a rejected access.

Function
REQ-015 The FSM SHALL have states INIT and RUN; reset enters INIT with word counter = 0.
REQ-016 In INIT, write zero to word[counter] each cycle and increment; after word MEMDEPTH-1, go to RUN; ready rises the next cycle (MEMDEPTH cycles after reset release).
REQ-017 In INIT, all requests SHALL be ignored: no write, no rvalid, no err.
REQ-018 In RUN, word index = addr[ADDRWIDTH-1:log2(DATAWIDTH/8)]; byte lane = low address bits.
REQ-019 Access is illegal if size bytes > DATAWIDTH/8, or addr is not a multiple of size bytes.
REQ-020 Legal write: update only the 2^size byte lanes starting at the lane offset; other lanes unchanged; no rvalid, no err.
REQ-021 Legal read: rdata carries selected lanes in place, other lanes zero; rvalid pulses 1 cycle after the request (latency 1).
REQ-022 Illegal access: no memory change; err pulses at the cycle rvalid would have; rdata = 0 in that cycle.
REQ-023 Both ports writing the same word in one cycle: overlapping byte lanes take port A data; non-overlapping lanes from each port both commit.
REQ-024 Read on one port and write on the other to the same word in one cycle: the read SHALL return pre-write contents (read-first).
REQ-025 rdata SHALL hold its last value when rvalid and err are low.
REQ-026 Ports are fully independent; both may complete one access per cycle, no stalls in RUN.

Reset
REQ-027 On HRESETn low: ready, rvalid_a/b, err_a/b = 0; rdata_a/b = 0; FSM = INIT; counter = 0; pending reads discarded.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL restart initialisation from word 0 after release.

Configuration
REQ-029 Macro SIZED_DP_RAM_OUTREG_EN defined: an extra output register stage; rdata/rvalid/err latency = 2 cycles, collision rules unchanged.
REQ-030 Macro undefined: latency = 1 cycle as in REQ-021/REQ-022.

Structure
REQ-031 Package ahb_lite_defs SHALL hold hsize_t (with DWORD added) and the default DATAWIDTH/MEMDEPTH/ADDRWIDTH constants.
REQ-032 Sub-module dp_ram_lane_decode SHALL compute byte-enable mask and illegal flag from size, address offset and DATAWIDTH; instantiated once per port.

Verification (DATAWIDTH=32, MEMDEPTH=1024, no OUTREG unless noted)
REQ-033 Release reset, hold en_a high -> ready rises exactly 1024 cycles later; no rvalid_a/err_a before; word reads of 0x000 and 0xFFC return 0.
REQ-034 Write WORD 0x11223344 @0x010, write BYTE 0x00AA0000 @0x012, read WORD @0x010 -> rdata 0x11AA3344 one cycle later.
REQ-035 Read HALFWORD @0x011 -> err_a pulse, rdata 0, memory unchanged; read DWORD @0x000 -> err_a pulse.
REQ-036 Same cycle: A writes WORD 0xAAAAAAAA @0x020, B writes HALFWORD 0x0000BBBB @0x020 -> word reads 0xAAAAAAAA; with B at @0x022 (0xBBBB0000) -> word reads 0xAAAAAAAA (A wins overlap).
REQ-037 Same cycle: A writes 0x55 byte @0x030 (old 0x0), B reads WORD @0x030 -> rdata_b 0x00000000; next B read -> 0x00000055.
REQ-038 Assert reset mid-INIT at cycle 500 and mid-read in RUN -> outputs zero immediately, rvalid suppressed, ready returns 1024 cycles after release; repeat REQ-034 with SIZED_DP_RAM_OUTREG_EN -> rvalid at 2 cycles.

Source files
------------

// File: rtl/ahb_lite_defs.sv
// Shared definitions for sized_dp_ram: AHB-style transfer size encoding
// (extended with DWORD), the controller state type and the default geometry.
package ahb_lite_defs;

    typedef enum logic [2:0] {
        BYTE     = 3'd0,
        HALFWORD = 3'd1,
        WORD     = 3'd2,
        DWORD    = 3'd3
    } hsize_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_t;

    localparam int DEF_DATAWIDTH = 32;
    localparam int DEF_MEMDEPTH  = 1024;
    localparam int DEF_ADDRWIDTH = 12;

endpackage

// File: rtl/dp_ram_lane_decode.sv
// Byte-lane decoder for one sized_dp_ram port: turns an access size and the
// byte offset inside a word into a byte-enable mask plus an illegal flag.
// Illegal means wider than the word or not naturally aligned; the mask is
// all-zero for illegal accesses so nothing downstream can commit.
module dp_ram_lane_decode
    import ahb_lite_defs::*;
#(
    parameter  int DATAWIDTH = DEF_DATAWIDTH,
    localparam int NBYTES    = DATAWIDTH / 8,
    localparam int LANEBITS  = $clog2(NBYTES)
) (
    input  hsize_t              size_i,
    input  logic [LANEBITS-1:0] offset_i,
    output logic [NBYTES-1:0]   byte_en_o,
    output logic                illegal_o
);

    int nbytes;
    int off;

    // Size/alignment legality and the contiguous lane window it selects
    always_comb begin
        nbytes    = 1 << int'(size_i);
        off       = int'(offset_i);
        illegal_o = (nbytes > NBYTES) || ((off % nbytes) != 0);
        byte_en_o = '0;
        for (int i = 0; i < NBYTES; i++) begin
            byte_en_o[i] = !illegal_o && (i >= off) && (i < off + nbytes);
        end
    end

endmodule

// File: rtl/sized_dp_ram.sv
// Dual-port byte-addressed RAM with sized (byte/half/word/dword) accesses.
// After reset the array is zero-filled one word per cycle (INIT); ready rises
// when that finishes and both ports then serve one access per cycle (RUN).
// Collisions: overlapping write lanes take port A, reads are read-first.
// Build option: define SIZED_DP_RAM_OUTREG_EN to add an output register stage
// (response latency 2 instead of 1).
//
// Handshake: a request is en_x high for one cycle while ready is high. A legal
// read answers with a one-cycle rvalid_x pulse, an illegal access with a
// one-cycle err_x pulse (rdata_x = 0), both at the fixed latency; writes give
// no response. There is no backpressure and rdata_x holds between responses.
module sized_dp_ram
    import ahb_lite_defs::*;
#(
    parameter int DATAWIDTH = DEF_DATAWIDTH,
    parameter int MEMDEPTH  = DEF_MEMDEPTH,
    parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    output logic                 ready,
    output ram_state_t           fsm_state,
    input  logic                 en_a,
    input  logic                 we_a,
    input  logic [ADDRWIDTH-1:0] addr_a,
    input  hsize_t               size_a,
    input  logic [DATAWIDTH-1:0] wdata_a,
    output logic [DATAWIDTH-1:0] rdata_a,
    output logic                 rvalid_a,
    output logic                 err_a,
    input  logic                 en_b,
    input  logic                 we_b,
    input  logic [ADDRWIDTH-1:0] addr_b,
    input  hsize_t               size_b,
    input  logic [DATAWIDTH-1:0] wdata_b,
    output logic [DATAWIDTH-1:0] rdata_b,
    output logic                 rvalid_b,
    output logic                 err_b
);

    localparam int NBYTES   = DATAWIDTH / 8;
    localparam int LANEBITS = $clog2(NBYTES);
    localparam int IDXW     = ADDRWIDTH - LANEBITS;
    localparam int CNTW     = $clog2(MEMDEPTH);

    logic [DATAWIDTH-1:0] mem [MEMDEPTH];

    ram_state_t           state_q;
    logic [CNTW-1:0]      cnt_q;
    logic                 ready_q;
    logic                 rvalid_a_q, rvalid_b_q, err_a_q, err_b_q;
    logic [DATAWIDTH-1:0] rdata_a_q, rdata_b_q, rdata_a_d, rdata_b_d;

    logic [NBYTES-1:0]    be_a, be_b;
    logic                 ill_a, ill_b;
    logic [DATAWIDTH-1:0] mask_a, mask_b;
    logic [IDXW-1:0]      idx_a, idx_b;
    logic                 run, wr_a, wr_b, rd_a, rd_b, er_a, er_b;

    dp_ram_lane_decode #(.DATAWIDTH(DATAWIDTH)) u_dec_a (
        .size_i    (size_a),
        .offset_i  (addr_a[LANEBITS-1:0]),
        .byte_en_o (be_a),
        .illegal_o (ill_a)
    );

    dp_ram_lane_decode #(.DATAWIDTH(DATAWIDTH)) u_dec_b (
        .size_i    (size_b),
        .offset_i  (addr_b[LANEBITS-1:0]),
        .byte_en_o (be_b),
        .illegal_o (ill_b)
    );

    assign idx_a = addr_a[ADDRWIDTH-1:LANEBITS];
    assign idx_b = addr_b[ADDRWIDTH-1:LANEBITS];
    assign run   = (state_q == ST_RUN);
    assign wr_a  = run && en_a && we_a && !ill_a;
    assign wr_b  = run && en_b && we_b && !ill_b;
    assign rd_a  = run && en_a && !we_a && !ill_a;
    assign rd_b  = run && en_b && !we_b && !ill_b;
    assign er_a  = run && en_a && ill_a;
    assign er_b  = run && en_b && ill_b;

    // Next read data: selected lanes in place, zero on error, hold otherwise
    always_comb begin
        mask_a = '0;
        mask_b = '0;
        for (int l = 0; l < NBYTES; l++) begin
            mask_a[8*l +: 8] = {8{be_a[l]}};
            mask_b[8*l +: 8] = {8{be_b[l]}};
        end
        rdata_a_d = rdata_a_q;
        if (rd_a)      rdata_a_d = mem[idx_a] & mask_a;
        else if (er_a) rdata_a_d = '0;
        rdata_b_d = rdata_b_q;
        if (rd_b)      rdata_b_d = mem[idx_b] & mask_b;
        else if (er_b) rdata_b_d = '0;
    end

    // Array writes: zero-fill in INIT; in RUN port A is applied after B so it wins shared lanes
    always_ff @(posedge HCLK) begin
        if (!run) begin
            mem[cnt_q] <= '0;
        end else begin
            for (int l = 0; l < NBYTES; l++) begin
                if (wr_b && be_b[l]) mem[idx_b][8*l +: 8] <= wdata_b[8*l +: 8];
            end
            for (int l = 0; l < NBYTES; l++) begin
                if (wr_a && be_a[l]) mem[idx_a][8*l +: 8] <= wdata_a[8*l +: 8];
            end
        end
    end

    // INIT/RUN sequencing and the first response register stage
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            rvalid_a_q <= rd_a;
            rvalid_b_q <= rd_b;
            err_a_q    <= er_a;
            err_b_q    <= er_b;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(MEMDEPTH - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN:  state_q <= ST_RUN;
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign ready     = ready_q;
    assign fsm_state = state_q;

`ifdef SIZED_DP_RAM_OUTREG_EN
    logic                 rvalid_a_q2, rvalid_b_q2, err_a_q2, err_b_q2;
    logic [DATAWIDTH-1:0] rdata_a_q2, rdata_b_q2;

    // Second response stage; copying continuously preserves the hold behaviour
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rvalid_a_q2 <= 1'b0;
            rvalid_b_q2 <= 1'b0;
            err_a_q2    <= 1'b0;
            err_b_q2    <= 1'b0;
            rdata_a_q2  <= '0;
            rdata_b_q2  <= '0;
        end else begin
            rvalid_a_q2 <= rvalid_a_q;
            rvalid_b_q2 <= rvalid_b_q;
            err_a_q2    <= err_a_q;
            err_b_q2    <= err_b_q;
            rdata_a_q2  <= rdata_a_q;
            rdata_b_q2  <= rdata_b_q;
        end
    end

    assign rvalid_a = rvalid_a_q2;
    assign rvalid_b = rvalid_b_q2;
    assign err_a    = err_a_q2;
    assign err_b    = err_b_q2;
    assign rdata_a  = rdata_a_q2;
    assign rdata_b  = rdata_b_q2;
`else
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;
    assign err_a    = err_a_q;
    assign err_b    = err_b_q;
    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
`endif

endmodule

// File: tb/tb_sized_dp_ram.sv
// Bench for sized_dp_ram (DATAWIDTH=32, MEMDEPTH=1024). Reference model is a
// flat byte array; responses are queued per port and compared after the
// configured latency (1, or 2 with SIZED_DP_RAM_OUTREG_EN).
module tb_sized_dp_ram;
    import ahb_lite_defs::*;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
`ifdef SIZED_DP_RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    typedef struct {
        logic        en;
        logic        we;
        logic [11:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } req_t;

    // ---------------- clock / reset ----------------
    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic          ready;
    ram_state_t    fsm_state;
    logic          en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0;
    logic [11:0]   addr_a = '0, addr_b = '0;
    hsize_t        size_a = BYTE, size_b = BYTE;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic [DW-1:0] rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b, err_a, err_b;

    sized_dp_ram #(.DATAWIDTH(32), .MEMDEPTH(1024), .ADDRWIDTH(12)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .ready(ready), .fsm_state(fsm_state),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .size_a(size_a), .wdata_a(wdata_a),
        .rdata_a(rdata_a), .rvalid_a(rvalid_a), .err_a(err_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .size_b(size_b), .wdata_b(wdata_b),
        .rdata_b(rdata_b), .rvalid_b(rvalid_b), .err_b(err_b)
    );

    // ---------------- scoreboard state ----------------
    int n_vectors = 0;
    int n_miscompares = 0;
    logic [7:0]    mm [4096];         // byte-addressed reference memory
    logic [DW+1:0] exp_a_q[$];        // {rvalid, err, rdata}
    logic [DW+1:0] exp_b_q[$];
    logic [DW-1:0] last_a, last_b;    // value rdata is expected to hold
    int since_rel = 0;                // clock edges since reset release

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_legal(input logic [11:0] addr, input logic [2:0] size);
        int n;
        n = 1 << int'(size);
        return (n <= DW / 8) && ((int'(addr) % n) == 0);
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [11:0] addr, input logic [2:0] size);
        logic [DW-1:0] d;
        int n, lane;
        d = '0;
        n = 1 << int'(size);
        lane = int'(addr) % (DW / 8);
        for (int i = 0; i < n; i++) d[8*(lane+i) +: 8] = mm[int'(addr) + i];
        return d;
    endfunction

    task automatic model_write(input req_t r);
        int n, lane;
        n = 1 << int'(r.size);
        lane = int'(r.addr) % (DW / 8);
        for (int i = 0; i < n; i++) mm[int'(r.addr) + i] = r.wdata[8*(lane+i) +: 8];
    endtask

    function automatic logic [DW+1:0] model_resp(input req_t r, input bit acc, input logic [DW-1:0] last);
        if (acc && r.en && !is_legal(r.addr, r.size)) return {2'b01, {DW{1'b0}}};
        if (acc && r.en && !r.we) return {2'b10, model_read(r.addr, r.size)};
        return {2'b00, last};
    endfunction

    function automatic req_t mk(input logic en, input logic we, input logic [11:0] addr,
                                input logic [2:0] size, input logic [31:0] wdata);
        req_t r;
        r.en = en; r.we = we; r.addr = addr; r.size = size; r.wdata = wdata;
        return r;
    endfunction

    function automatic req_t idle();
        return mk(1'b0, 1'b0, 12'h0, 3'd0, 32'h0);
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.en    = ($urandom_range(0, 9) < 7);
        r.we    = 1'($urandom_range(0, 1));
        r.size  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        r.addr  = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 63));
        r.wdata = $urandom;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input req_t ra, input req_t rb);
        en_a = ra.en; we_a = ra.we; addr_a = ra.addr; size_a = hsize_t'(ra.size); wdata_a = ra.wdata;
        en_b = rb.en; we_b = rb.we; addr_b = rb.addr; size_b = hsize_t'(rb.size); wdata_b = rb.wdata;
    endtask

    // One clock: called at a negedge, drives, predicts, then checks at the next negedge
    task automatic step(input req_t ra, input req_t rb);
        logic [DW+1:0] ea, eb, ga, gb;
        bit acc;
        drive(ra, rb);
        acc = (since_rel >= DEPTH);
        ea = model_resp(ra, acc, last_a);
        eb = model_resp(rb, acc, last_b);
        last_a = ea[DW-1:0];
        last_b = eb[DW-1:0];
        if (acc && rb.en && rb.we && is_legal(rb.addr, rb.size)) model_write(rb);
        if (acc && ra.en && ra.we && is_legal(ra.addr, ra.size)) model_write(ra);
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        since_rel++;
        @(posedge HCLK);
        @(negedge HCLK);
        check_eq("ready", ready, since_rel >= DEPTH);
        check_eq("fsm_state", fsm_state, since_rel >= DEPTH);
        ga = exp_a_q.pop_front();
        gb = exp_b_q.pop_front();
        check_eq("rvalid_a", rvalid_a, ga[DW+1]);
        check_eq("err_a", err_a, ga[DW]);
        check_eq("rdata_a", rdata_a, ga[DW-1:0]);
        check_eq("rvalid_b", rvalid_b, gb[DW+1]);
        check_eq("err_b", err_b, gb[DW]);
        check_eq("rdata_b", rdata_b, gb[DW-1:0]);
    endtask

    // Assert reset right now, confirm outputs clear at once, release at a negedge
    task automatic do_reset();
        HRESETn = 1'b0;
        #1;
        check_eq("rst_ready", ready, 0);
        check_eq("rst_rvalid_a", rvalid_a, 0);
        check_eq("rst_rvalid_b", rvalid_b, 0);
        check_eq("rst_err_a", err_a, 0);
        check_eq("rst_err_b", err_b, 0);
        check_eq("rst_rdata_a", rdata_a, 0);
        check_eq("rst_rdata_b", rdata_b, 0);
        drive(idle(), idle());
        repeat (3) @(negedge HCLK);
        exp_a_q.delete();
        exp_b_q.delete();
        for (int i = 1; i < LAT; i++) begin
            exp_a_q.push_back('0);
            exp_b_q.push_back('0);
        end
        for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
        last_a = '0;
        last_b = '0;
        since_rel = 0;
        HRESETn = 1'b1;
    endtask

    task automatic flush();
        repeat (LAT + 1) step(idle(), idle());
    endtask

    task automatic directed_basic();
        // word write, byte overwrite in lane 2, word read back
        step(mk(1, 1, 12'h010, 3'd2, 32'h11223344), idle());
        step(mk(1, 1, 12'h012, 3'd0, 32'h00AA0000), idle());
        step(mk(1, 0, 12'h010, 3'd2, 32'h0), idle());
        flush();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (2) @(negedge HCLK);
        do_reset();

        // Init with a read held on port A: ignored until ready
        repeat (DEPTH) step(mk(1, 0, 12'h000, 3'd2, 32'h0), idle());
        step(mk(1, 0, 12'h000, 3'd2, 32'h0), idle());
        step(mk(1, 0, 12'hFFC, 3'd2, 32'h0), mk(1, 0, 12'hFFC, 3'd2, 32'h0));
        flush();

        directed_basic();

        // Misaligned halfword and oversize dword are rejected, memory intact
        step(mk(1, 0, 12'h011, 3'd1, 32'h0), idle());
        step(mk(1, 0, 12'h000, 3'd3, 32'h0), idle());
        step(mk(1, 1, 12'h011, 3'd1, 32'hFFFFFFFF), mk(1, 1, 12'h013, 3'd2, 32'hFFFFFFFF));
        step(mk(1, 0, 12'h010, 3'd2, 32'h0), idle());
        flush();

        // Same-word writes: port A owns overlapping lanes
        step(mk(1, 1, 12'h020, 3'd2, 32'hAAAAAAAA), mk(1, 1, 12'h020, 3'd1, 32'h0000BBBB));
        step(mk(1, 0, 12'h020, 3'd2, 32'h0), idle());
        step(mk(1, 1, 12'h020, 3'd2, 32'hAAAAAAAA), mk(1, 1, 12'h022, 3'd1, 32'hBBBB0000));
        step(mk(1, 0, 12'h020, 3'd2, 32'h0), idle());
        step(mk(1, 1, 12'h024, 3'd0, 32'h000000CC), mk(1, 1, 12'h026, 3'd1, 32'hDDDD0000));
        step(idle(), mk(1, 0, 12'h024, 3'd2, 32'h0));
        flush();

        // Read-first on a write/read collision
        step(mk(1, 1, 12'h030, 3'd0, 32'h00000055), mk(1, 0, 12'h030, 3'd2, 32'h0));
        step(idle(), mk(1, 0, 12'h030, 3'd2, 32'h0));
        step(mk(1, 0, 12'h030, 3'd0, 32'h0), mk(1, 1, 12'h031, 3'd0, 32'h00006600));
        step(mk(1, 0, 12'h030, 3'd1, 32'h0), idle());
        flush();

        // Random dual-port traffic concentrated on a few words
        repeat (1500) step(rand_req(), rand_req());
        flush();

        // Reset in the middle of a read in RUN
        step(mk(1, 0, 12'h010, 3'd2, 32'h0), mk(1, 0, 12'h030, 3'd2, 32'h0));
        drive(mk(1, 0, 12'h010, 3'd2, 32'h0), mk(1, 0, 12'h020, 3'd2, 32'h0));
        #2;
        do_reset();
        repeat (500) step(rand_req(), rand_req());

        // Reset in the middle of INIT, then a full re-initialisation
        #2;
        do_reset();
        repeat (DEPTH) step(rand_req(), rand_req());
        step(mk(1, 0, 12'h020, 3'd2, 32'h0), mk(1, 0, 12'h010, 3'd2, 32'h0));
        directed_basic();
        repeat (400) step(rand_req(), rand_req());
        flush();

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
